// File: rtl/bcd_to_binary.sv
// Converts a three-digit BCD number to binary using reverse double-dabble.
// Optional macro BCD2BIN_DIGIT_CHECK_EN enables flagging of illegal digits (>9).
module bcd_to_binary #(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       hundreds_in,
    input  logic [3:0]       tens_in,
    input  logic [3:0]       ones_in,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] bin_out,
    output logic             overflow,
    output logic             invalid
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [21:0]        work_q, work_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   bin_q, bin_d;
    logic               ovf_q, ovf_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic               bad_q, bad_d;
    logic               inv_q, inv_d;
`endif

    function automatic logic [3:0] fix_nibble(input logic [3:0] n);
        return (n >= 4'd8) ? n - 4'd3 : n;
    endfunction

    // One reverse double-dabble step: shift right, then correct each BCD nibble.
    function automatic logic [21:0] dabble_step(input logic [21:0] w);
        logic [21:0] s;
        s        = w >> 1;
        s[21:18] = fix_nibble(s[21:18]);
        s[17:14] = fix_nibble(s[17:14]);
        s[13:10] = fix_nibble(s[13:10]);
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        bad_d   = bad_q;
        inv_d   = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = {hundreds_in, tens_in, ones_in, 10'b0};
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    bad_d   = (hundreds_in > 4'd9) || (tens_in > 4'd9) || (ones_in > 4'd9);
`endif
                end
            end
            SHIFT: begin
                work_d = dabble_step(work_q);
                if (cnt_q == 4'd9) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                bin_d   = work_q[OUT_W-1:0];
                ovf_d   = ({2'b00, work_q[9:0]} >= (12'd1 << OUT_W));
`ifdef BCD2BIN_DIGIT_CHECK_EN
                inv_d   = bad_q;
                if (bad_q) begin
                    bin_d = '0;
                    ovf_d = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_q   <= 1'b0;
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_q   <= bad_d;
            inv_q   <= inv_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bin_out  = bin_q;
    assign overflow = ovf_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign invalid  = inv_q;
`else
    assign invalid  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Randomized self-checking bench for bcd_to_binary; runs OUT_W=8 and OUT_W=10 instances in parallel.
module tb_bcd_to_binary;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] h_in, t_in, o_in;

    logic       busy8, done8, ovf8, inv8;
    logic [7:0] bin8;
    logic       busy10, done10, ovf10, inv10;
    logic [9:0] bin10;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_to_binary #(.OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .hundreds_in(h_in), .tens_in(t_in), .ones_in(o_in),
        .busy(busy8), .done(done8), .bin_out(bin8), .overflow(ovf8), .invalid(inv8)
    );

    bcd_to_binary #(.OUT_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .hundreds_in(h_in), .tens_in(t_in), .ones_in(o_in),
        .busy(busy10), .done(done10), .bin_out(bin10), .overflow(ovf10), .invalid(inv10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value by plain arithmetic, truncated to the result width.
    task automatic model(input int h, input int t, input int o, input int w,
                         output logic [31:0] bin, output logic ovf, output logic inv);
        int val;
        val = h * 100 + t * 10 + o;
        bin = val % (1 << w);
        ovf = (val >= (1 << w));
        inv = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if (h > 9 || t > 9 || o > 9) begin
            bin = 0;
            ovf = 1'b0;
            inv = 1'b1;
        end
`endif
    endtask

    task automatic check_outputs(input string tag, input int h, input int t, input int o);
        logic [31:0] eb;
        logic        eo, ei;
        model(h, t, o, 8, eb, eo, ei);
        chk({tag, "_bin8"}, 32'(bin8), eb);
        chk({tag, "_ovf8"}, 32'(ovf8), 32'(eo));
        chk({tag, "_inv8"}, 32'(inv8), 32'(ei));
        model(h, t, o, 10, eb, eo, ei);
        chk({tag, "_bin10"}, 32'(bin10), eb);
        chk({tag, "_ovf10"}, 32'(ovf10), 32'(eo));
    endtask

    // Start one conversion; optionally disturb start/digits mid-SHIFT.
    task automatic do_conv(input string tag, input int h, input int t, input int o, input bit scramble);
        int  n;
        bit  busy_ok;
        @(negedge clk);
        h_in = 4'(h); t_in = 4'(t); o_in = 4'(o);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ok = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            if (scramble && i == 3) begin
                start = 1'b1; h_in = 4'd4; t_in = 4'd5; o_in = 4'd6;
            end
            if (scramble && i == 6) start = 1'b0;
            if (!(busy8 && busy10)) busy_ok = 1'b0;
            @(posedge clk); #1;
            if (done8) begin
                n = i;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'd11);
        chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, "_done10"}, 32'(done10), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy8), 32'd0);
        check_outputs(tag, h, t, o);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done8), 32'd0);
        check_outputs({tag, "_hold"}, h, t, o);
    endtask

    initial begin
        int dn, first, second, cyc;
        rst_n = 1'b0; start = 1'b0; h_in = '0; t_in = '0; o_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_bin", 32'(bin8), 0);
        chk("rst_ovf", 32'(ovf8), 0);
        chk("rst_inv", 32'(inv8), 0);
        rst_n = 1'b1;

        do_conv("d255", 2, 5, 5, 1'b0);
        do_conv("d256", 2, 5, 6, 1'b0);
        do_conv("d999", 9, 9, 9, 1'b0);
        do_conv("d000", 0, 0, 0, 1'b0);
        do_conv("scr123", 1, 2, 3, 1'b1);

        // Abort a conversion with a one-cycle reset during SHIFT.
        @(negedge clk);
        h_in = 4'd1; t_in = 4'd2; o_in = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy8), 0);
        chk("abort_bin", 32'(bin8), 0);
        chk("abort_ovf", 32'(ovf8), 0);
        chk("abort_done", 32'(done8), 0);
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) dn++;
        end
        chk("abort_quiet", 32'(dn), 0);
        do_conv("d042", 0, 4, 2, 1'b0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        do_conv("bad1A3", 1, 10, 3, 1'b0);
        do_conv("ok007", 0, 0, 7, 1'b0);
`endif

        for (int k = 0; k < 20; k++) begin
            int h, t, o;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            h = $urandom_range(0, 15); t = $urandom_range(0, 15); o = $urandom_range(0, 15);
`else
            h = $urandom_range(0, 9); t = $urandom_range(0, 9); o = $urandom_range(0, 9);
`endif
            do_conv($sformatf("rnd%0d", k), h, t, o, 1'b0);
        end

        // start held high: conversions every 12 cycles.
        @(negedge clk);
        h_in = 4'd3; t_in = 4'd0; o_in = 4'd7; start = 1'b1;
        first = -1; second = -1; dn = 0;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            if (done8) begin
                dn++;
                if (dn == 1) first = cyc;
                if (dn == 2) second = cyc;
                if (dn == 3) begin
                    chk("b2b_gap1", 32'(second - first), 12);
                    chk("b2b_gap2", 32'(cyc - second), 12);
                    check_outputs("b2b", 3, 0, 7);
                    break;
                end
            end
        end
        chk("b2b_count", 32'(dn), 3);
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!busy8) break;
            dn++;
        end
        chk("b2b_drain", 32'(dn < 20), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
